move_arbiter: RTL and testbench

MOVE_ARBITER -- requirements
Module: move_arbiter

---
 rtl/tank_pkg.sv | 30 +++
 rtl/move_checker.sv | 61 ++++++
 rtl/move_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_move_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/tank_pkg.sv
// Shared encodings and geometry for the two-tank move arbiter.
package tank_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam int TANK_SIZE     = 9;
    localparam int STEP          = 9;
    localparam int X_MAX         = 151;
    localparam int Y_MAX         = 111;
    localparam int ISSUE_TIMEOUT = 15;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_MOVING = 2'd2
    } tank_state_e;

    typedef enum logic {
        PH_WAIT = 1'b0,
        PH_RUN  = 1'b1
    } phase_e;

    function automatic logic [8:0] abs_diff9(input logic [8:0] a, input logic [8:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/move_checker.sv
// Combinational legality check for one proposed move: playfield bounds plus overlap with the other tank.
module move_checker #(
    parameter int TANK_SIZE = tank_pkg::TANK_SIZE,
    parameter int STEP      = tank_pkg::STEP,
    parameter int X_MAX     = tank_pkg::X_MAX,
    parameter int Y_MAX     = tank_pkg::Y_MAX
) (
    input  logic [7:0] x,
    input  logic [6:0] y,
    input  logic [1:0] dir,
    input  logic [8:0] other_x,
    input  logic [8:0] other_y,
    output logic [8:0] tgt_x,
    output logic [8:0] tgt_y,
    output logic       legal
);
    import tank_pkg::*;

    localparam logic [8:0] STEP9 = 9'(STEP);
    localparam logic [8:0] SIZE9 = 9'(TANK_SIZE);
    localparam logic [8:0] XMAX9 = 9'(X_MAX);
    localparam logic [8:0] YMAX9 = 9'(Y_MAX);

    logic [8:0] x9;
    logic [8:0] y9;
    logic [8:0] dx;
    logic [8:0] dy;
    logic       in_bounds;

    assign x9 = {1'b0, x};
    assign y9 = {2'b00, y};

    // Widened to 9 bits so x+STEP / y+STEP can never wrap past the limit check.
    always_comb begin
        tgt_x     = x9;
        tgt_y     = y9;
        in_bounds = 1'b0;
        case (dir)
            DIR_UP: begin
                in_bounds = (y9 >= STEP9);
                tgt_y     = y9 - STEP9;
            end
            DIR_DOWN: begin
                tgt_y     = y9 + STEP9;
                in_bounds = (tgt_y <= YMAX9);
            end
            DIR_LEFT: begin
                in_bounds = (x9 >= STEP9);
                tgt_x     = x9 - STEP9;
            end
            default: begin
                tgt_x     = x9 + STEP9;
                in_bounds = (tgt_x <= XMAX9);
            end
        endcase
        dx    = abs_diff9(tgt_x, other_x);
        dy    = abs_diff9(tgt_y, other_y);
        legal = in_bounds && !((dx < SIZE9) && (dy < SIZE9));
    end

endmodule

// File: rtl/move_arbiter.sv
// Two-tank move arbiter: one shared legality check per cycle, round-robin between requesting idle tanks.
module move_arbiter #(
    parameter int TANK_SIZE     = tank_pkg::TANK_SIZE,
    parameter int STEP          = tank_pkg::STEP,
    parameter int X_MAX         = tank_pkg::X_MAX,
    parameter int Y_MAX         = tank_pkg::Y_MAX,
    parameter int ISSUE_TIMEOUT = tank_pkg::ISSUE_TIMEOUT
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       p1_req,
    input  logic [1:0] p1_dir,
    input  logic       p2_req,
    input  logic [1:0] p2_dir,
    input  logic [7:0] t1_x,
    input  logic [6:0] t1_y,
    input  logic [7:0] t2_x,
    input  logic [6:0] t2_y,
    input  logic       t1_moving,
    input  logic       t2_moving,
    output logic [2:0] t1_direction,
    output logic [2:0] t2_direction,
    output logic [1:0] t1_facing,
    output logic [1:0] t2_facing,
    output logic       t1_blocked,
    output logic       t2_blocked,
    output logic       t1_fault,
    output logic       t2_fault
);
    import tank_pkg::*;

    localparam int TW = $clog2(ISSUE_TIMEOUT + 1);

    logic [7:0] x_in [2];
    logic [6:0] y_in [2];
    logic [1:0] dir_in [2];
    logic       req_in [2];
    logic       moving_in [2];

    assign x_in[0] = t1_x;      assign x_in[1] = t2_x;
    assign y_in[0] = t1_y;      assign y_in[1] = t2_y;
    assign dir_in[0] = p1_dir;  assign dir_in[1] = p2_dir;
    assign req_in[0] = p1_req;  assign req_in[1] = p2_req;
    assign moving_in[0] = t1_moving;
    assign moving_in[1] = t2_moving;

    phase_e      phase_q, phase_d;
    logic        ptr_q, ptr_d;
    tank_state_e state_q [2];
    tank_state_e state_d [2];
    logic [8:0]  tgt_x_q [2];
    logic [8:0]  tgt_x_d [2];
    logic [8:0]  tgt_y_q [2];
    logic [8:0]  tgt_y_d [2];
    logic [2:0]  cmd_q [2];
    logic [2:0]  cmd_d [2];
    logic [1:0]  facing_q [2];
    logic [1:0]  facing_d [2];
    logic        blocked_q [2];
    logic        blocked_d [2];
    logic        fault_q [2];
    logic        fault_d [2];
    logic [TW-1:0] timer_q [2];
    logic [TW-1:0] timer_d [2];

    logic [1:0] elig;
    logic       eval_en;
    logic       sel;
    logic       oth;
    logic [8:0] other_x;
    logic [8:0] other_y;
    logic [8:0] chk_tx;
    logic [8:0] chk_ty;
    logic       chk_legal;

    // A tank already committed to a move is represented by where it is going, not where it is.
    always_comb begin
        elig[0] = (phase_q == PH_RUN) && (state_q[0] == ST_IDLE) && req_in[0];
        elig[1] = (phase_q == PH_RUN) && (state_q[1] == ST_IDLE) && req_in[1];
        eval_en = |elig;
        sel     = (elig[0] && elig[1]) ? ptr_q : elig[1];
        oth     = ~sel;
        if (state_q[oth] != ST_IDLE) begin
            other_x = tgt_x_q[oth];
            other_y = tgt_y_q[oth];
        end else begin
            other_x = {1'b0, x_in[oth]};
            other_y = {2'b00, y_in[oth]};
        end
    end

    move_checker #(
        .TANK_SIZE(TANK_SIZE),
        .STEP     (STEP),
        .X_MAX    (X_MAX),
        .Y_MAX    (Y_MAX)
    ) u_checker (
        .x      (x_in[sel]),
        .y      (y_in[sel]),
        .dir    (dir_in[sel]),
        .other_x(other_x),
        .other_y(other_y),
        .tgt_x  (chk_tx),
        .tgt_y  (chk_ty),
        .legal  (chk_legal)
    );

    always_comb begin
        phase_d = (phase_q == PH_WAIT && start) ? PH_RUN : phase_q;
        ptr_d   = eval_en ? ~ptr_q : ptr_q;
        for (int i = 0; i < 2; i++) begin
            state_d[i]   = state_q[i];
            tgt_x_d[i]   = tgt_x_q[i];
            tgt_y_d[i]   = tgt_y_q[i];
            cmd_d[i]     = cmd_q[i];
            facing_d[i]  = facing_q[i];
            blocked_d[i] = 1'b0;
            fault_d[i]   = fault_q[i];
            timer_d[i]   = timer_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    cmd_d[i] = 3'b000;
                    if (eval_en && (sel == i[0])) begin
                        facing_d[i] = dir_in[i];
                        if (chk_legal) begin
                            state_d[i] = ST_ISSUE;
                            tgt_x_d[i] = chk_tx;
                            tgt_y_d[i] = chk_ty;
                            cmd_d[i]   = {1'b1, dir_in[i]};
                            timer_d[i] = '0;
                        end else begin
                            blocked_d[i] = 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (moving_in[i]) begin
                        state_d[i] = ST_MOVING;
                        cmd_d[i]   = 3'b000;
                    end else if (timer_q[i] == TW'(ISSUE_TIMEOUT - 1)) begin
                        state_d[i] = ST_IDLE;
                        fault_d[i] = 1'b1;
                        cmd_d[i]   = 3'b000;
                    end else begin
                        timer_d[i] = timer_q[i] + 1'b1;
                    end
                end
                ST_MOVING: begin
                    cmd_d[i] = 3'b000;
                    if (!moving_in[i]) begin
                        state_d[i] = ST_IDLE;
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                    cmd_d[i]   = 3'b000;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            phase_q <= PH_WAIT;
            ptr_q   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                state_q[i]   <= ST_IDLE;
                tgt_x_q[i]   <= '0;
                tgt_y_q[i]   <= '0;
                cmd_q[i]     <= 3'b000;
                facing_q[i]  <= 2'b00;
                blocked_q[i] <= 1'b0;
                fault_q[i]   <= 1'b0;
                timer_q[i]   <= '0;
            end
        end else begin
            phase_q <= phase_d;
            ptr_q   <= ptr_d;
            for (int i = 0; i < 2; i++) begin
                state_q[i]   <= state_d[i];
                tgt_x_q[i]   <= tgt_x_d[i];
                tgt_y_q[i]   <= tgt_y_d[i];
                cmd_q[i]     <= cmd_d[i];
                facing_q[i]  <= facing_d[i];
                blocked_q[i] <= blocked_d[i];
                fault_q[i]   <= fault_d[i];
                timer_q[i]   <= timer_d[i];
            end
        end
    end

    assign t1_direction = cmd_q[0];
    assign t2_direction = cmd_q[1];
    assign t1_facing    = facing_q[0];
    assign t2_facing    = facing_q[1];
    assign t1_blocked   = blocked_q[0];
    assign t2_blocked   = blocked_q[1];
    assign t1_fault     = fault_q[0];
    assign t2_fault     = fault_q[1];

endmodule

// File: tb/tb_move_arbiter.sv
// Scoreboard bench: stimulus queues expected output changes; a monitor checks every change the DUT makes.
module tb_move_arbiter;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic       p1_req = 1'b0, p2_req = 1'b0;
    logic [1:0] p1_dir = 2'd0, p2_dir = 2'd0;
    logic [7:0] t1_x = 8'd10, t2_x = 8'd200;
    logic [6:0] t1_y = 7'd50, t2_y = 7'd120;
    logic       t1_moving = 1'b0, t2_moving = 1'b0;
    logic [2:0] t1_direction, t2_direction;
    logic [1:0] t1_facing, t2_facing;
    logic       t1_blocked, t2_blocked, t1_fault, t2_fault;

    move_arbiter dut (
        .clk(clk), .resetn(resetn), .start(start),
        .p1_req(p1_req), .p1_dir(p1_dir), .p2_req(p2_req), .p2_dir(p2_dir),
        .t1_x(t1_x), .t1_y(t1_y), .t2_x(t2_x), .t2_y(t2_y),
        .t1_moving(t1_moving), .t2_moving(t2_moving),
        .t1_direction(t1_direction), .t2_direction(t2_direction),
        .t1_facing(t1_facing), .t2_facing(t2_facing),
        .t1_blocked(t1_blocked), .t2_blocked(t2_blocked),
        .t1_fault(t1_fault), .t2_fault(t2_fault)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int         cyc;
        int         tank;
        logic [6:0] outs;   // {direction, facing, blocked, fault}
    } exp_t;

    exp_t       exp_q[$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    bit         mon_en = 1'b0;
    bit         armed = 1'b0;
    bit         done = 1'b0;
    logic [6:0] last [2];
    logic [6:0] cur;
    logic [1:0] fac_m [2];
    logic       fault_m [2];
    exp_t       e;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] outs_of(input int t);
        if (t == 0) return {t1_direction, t1_facing, t1_blocked, t1_fault};
        return {t2_direction, t2_facing, t2_blocked, t2_fault};
    endfunction

    task automatic push_exp(input int c, input int t, input logic [2:0] d,
                            input logic [1:0] f, input logic b, input logic fl);
        exp_q.push_back('{cyc: c, tank: t, outs: {d, f, b, fl}});
    endtask

    task automatic set_req(input int t, input logic v, input logic [1:0] d);
        if (t == 0) begin p1_req = v; p1_dir = d; end
        else begin p2_req = v; p2_dir = d; end
    endtask

    task automatic set_moving(input int t, input logic v);
        if (t == 0) t1_moving = v; else t2_moving = v;
    endtask

    task automatic set_pos(input int t, input int x, input int y);
        if (t == 0) begin t1_x = 8'(x); t1_y = 7'(y); end
        else begin t2_x = 8'(x); t2_y = 7'(y); end
    endtask

    // Called at a falling edge with the target tank idle; runs one full request/acknowledge exchange.
    task automatic eval_move(input int t, input logic [1:0] d, input bit grant);
        int k;
        k = cyc;
        set_req(t, 1'b1, d);
        fac_m[t] = d;
        if (grant) begin
            push_exp(k + 1, t, {1'b1, d}, d, 1'b0, fault_m[t]);
            @(negedge clk); set_req(t, 1'b0, d);
            repeat (2) @(negedge clk);
            k = cyc;
            set_moving(t, 1'b1);
            push_exp(k + 1, t, 3'b000, d, 1'b0, fault_m[t]);
            @(negedge clk); set_moving(t, 1'b0);
            repeat (2) @(negedge clk);
        end else begin
            push_exp(k + 1, t, 3'b000, d, 1'b1, fault_m[t]);
            push_exp(k + 2, t, 3'b000, d, 1'b0, fault_m[t]);
            @(negedge clk); set_req(t, 1'b0, d);
            repeat (3) @(negedge clk);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            for (int t = 0; t < 2; t++) begin
                cur = outs_of(t);
                if (!armed) begin
                    checks++;
                    $display("reset tank=%0d outs=%b", t, cur);
                    if (cur != 7'd0) begin
                        errors++;
                        $display("FAIL reset_state tank=%0d got=%b want=%b", t, cur, 7'd0);
                    end
                    last[t] = cur;
                end else if (cur != last[t]) begin
                    checks++;
                    $display("evt cyc=%0d tank=%0d outs=%b", cyc, t, cur);
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_event tank=%0d cyc=%0d got=%b want=none", t, cyc, cur);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.cyc != cyc || e.tank != t || e.outs != cur) begin
                            errors++;
                            $display("FAIL event got tank=%0d cyc=%0d outs=%b want tank=%0d cyc=%0d outs=%b",
                                     t, cyc, cur, e.tank, e.cyc, e.outs);
                        end
                    end
                    last[t] = cur;
                end
            end
            armed = 1'b1;
        end
        if (done || cyc > 20000) begin
            checks++;
            if (!done) begin
                errors++;
                $display("FAIL watchdog got cyc=%0d want stimulus complete", cyc);
            end else if (exp_q.size() != 0) begin
                errors++;
                $display("FAIL pending_events got=%0d want=0", exp_q.size());
            end
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    initial begin
        int k;
        fac_m[0] = 2'd0;   fac_m[1] = 2'd0;
        fault_m[0] = 1'b0; fault_m[1] = 1'b0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        mon_en = 1'b1;

        // Requests before start must be ignored.
        set_req(0, 1'b1, 2'd0);
        repeat (4) @(negedge clk);
        set_req(0, 1'b0, 2'd0);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);

        set_pos(0, 10, 50); set_pos(1, 200, 120);
        eval_move(0, 2'd0, 1'b1);                       // up from (10,50)
        set_pos(0, 10, 5);   eval_move(0, 2'd0, 1'b0);  // up off the top edge
        set_pos(0, 60, 50); set_pos(1, 69, 50);
        eval_move(0, 2'd3, 1'b0);                       // right into idle tank 2
        set_pos(1, 80, 50);  eval_move(0, 2'd3, 1'b1);
        set_pos(1, 200, 120);
        set_pos(0, 142, 50); eval_move(0, 2'd3, 1'b1);  // lands exactly on X_MAX
        set_pos(0, 143, 50); eval_move(0, 2'd3, 1'b0);
        set_pos(0, 10, 102); eval_move(0, 2'd1, 1'b1);  // lands exactly on Y_MAX
        set_pos(0, 10, 103); eval_move(0, 2'd1, 1'b0);
        set_pos(0, 9, 50);   eval_move(0, 2'd2, 1'b1);
        set_pos(0, 8, 50);   eval_move(0, 2'd2, 1'b0);
        set_pos(0, 10, 9);   eval_move(0, 2'd0, 1'b1);
        set_pos(1, 100, 60); eval_move(1, 2'd0, 1'b1);

        // Simultaneous requests, pointer at tank 1: tank 2 is checked against tank 1's target (69,50).
        set_pos(0, 60, 50); set_pos(1, 80, 50);
        k = cyc;
        set_req(0, 1'b1, 2'd3); set_req(1, 1'b1, 2'd2);
        fac_m[0] = 2'd3; fac_m[1] = 2'd2;
        push_exp(k + 1, 0, 3'b111, 2'd3, 1'b0, 1'b0);
        push_exp(k + 2, 1, 3'b000, 2'd2, 1'b1, 1'b0);
        push_exp(k + 3, 1, 3'b000, 2'd2, 1'b0, 1'b0);
        @(negedge clk); set_req(0, 1'b0, 2'd3);
        @(negedge clk); set_req(1, 1'b0, 2'd2);
        @(negedge clk);
        k = cyc;
        set_moving(0, 1'b1);
        push_exp(k + 1, 0, 3'b000, 2'd3, 1'b0, 1'b0);
        @(negedge clk); set_moving(0, 1'b0);
        repeat (2) @(negedge clk);

        // Tank 1 never acknowledges: 15 issue cycles, then fault.
        set_pos(0, 10, 50);
        k = cyc;
        set_req(0, 1'b1, 2'd0);
        fac_m[0] = 2'd0;
        push_exp(k + 1, 0, 3'b100, 2'd0, 1'b0, 1'b0);
        push_exp(k + 16, 0, 3'b000, 2'd0, 1'b0, 1'b1);
        fault_m[0] = 1'b1;
        @(negedge clk); set_req(0, 1'b0, 2'd0);
        repeat (18) @(negedge clk);

        // Reset while tank 2 is moving.
        k = cyc;
        set_req(1, 1'b1, 2'd1);
        fac_m[1] = 2'd1;
        push_exp(k + 1, 1, 3'b101, 2'd1, 1'b0, 1'b0);
        @(negedge clk); set_req(1, 1'b0, 2'd1);
        @(negedge clk);
        k = cyc;
        set_moving(1, 1'b1);
        push_exp(k + 1, 1, 3'b000, 2'd1, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        k = cyc;
        resetn = 1'b0;
        push_exp(k + 1, 0, 3'b000, 2'd0, 1'b0, 1'b0);
        push_exp(k + 1, 1, 3'b000, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        resetn = 1'b1;
        set_moving(1, 1'b0);
        fac_m[0] = 2'd0; fac_m[1] = 2'd0;
        fault_m[0] = 1'b0; fault_m[1] = 1'b0;
        set_req(0, 1'b1, 2'd0);
        repeat (5) @(negedge clk);
        set_req(0, 1'b0, 2'd0);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        eval_move(0, 2'd0, 1'b1);

        repeat (2) @(negedge clk);
        done = 1'b1;
    end

endmodule
